pcileech_sysctl: RTL and testbench
==================================

Name: pcileech_sysctl

Overview:
Parametrised board system-control block: power-on/button reset sequencing, free-running 64-bit tick counter, N debounced active-low buttons with short/long-press detection, and M mode-selectable status LEDs with power-on blink. It sits beside the FIFO/PCIe/COM instances in each board top and drives their `rst`, config-reload request and LED pads. One instance serves any board variant.

Parameters:
NUM_BTN, 2, number of active-low user buttons (1..8)
NUM_LED, 2, number of LED outputs (1..8)
RST_BTN, 1, index of button acting as system reset / config reload
RST_HOLD_CYCLES, 64, cycles `sys_rst` stays high after reset sources release (>=1)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles to accept a button change (>=1)
LONG_PRESS_CYCLES, 500000000, held cycles for a long press (> DEBOUNCE_CYCLES)
BLINK_BIT, 24, tick bit driving blink
PWRON_BIT, 27, power-on blink lasts while tick[63:PWRON_BIT]==0

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_n  in  NUM_BTN  raw asynchronous button pads, low = pressed
sys_rst  out  1  active-high synchronous system reset to fabric
tickcount  out  64  cycles since last sys_rst release
btn_level  out  NUM_BTN  debounced pressed state, 1 = pressed
btn_short  out  NUM_BTN  1-cycle pulse on release after short press
btn_long  out  NUM_BTN  1-cycle pulse when long-press threshold reached
cfg_reload  out  1  level, high while RST_BTN held >= LONG_PRESS_CYCLES
led_mode  in  2*NUM_LED  per-LED mode, LED i uses [2i+1:2i]
led_act  in  NUM_LED  per-LED activity input
led_out  out  NUM_LED  LED drive, 1 = on

Behaviour:
- rst_n low: all outputs 0 except sys_rst=1; all counters 0; btn_level=0. Flops use async assert, clk-synchronous deassert.
- Button path per bit: 2-FF synchroniser on ~btn_n, then debounce counter; counter clears whenever synced value == btn_level, else increments; when it reaches DEBOUNCE_CYCLES-1, btn_level toggles, counter clears. Press-to-level latency = 2 + DEBOUNCE_CYCLES cycles. Glitch shorter than DEBOUNCE_CYCLES: no change.
- Hold counter per button: clears while btn_level=0; increments while 1, saturates at LONG_PRESS_CYCLES. btn_long pulses exactly once, on the cycle count becomes LONG_PRESS_CYCLES. btn_short pulses on the falling edge of btn_level only if count < LONG_PRESS_CYCLES.
- Reset FSM states: RST_ACTIVE, RST_HOLD, RUN. RST_ACTIVE while btn_level[RST_BTN]=1 (entered from any state); on release -> RST_HOLD with counter 0; RST_HOLD counts to RST_HOLD_CYCLES-1 -> RUN. sys_rst=1 in RST_ACTIVE/RST_HOLD, 0 in RUN. After rst_n release FSM starts in RST_HOLD.
- tickcount: 0 in RST_ACTIVE; +1 every cycle otherwise (including RST_HOLD); 64-bit wrap to 0 with no side effect.
- cfg_reload = btn_level[RST_BTN] & (hold count == LONG_PRESS_CYCLES); drops the cycle btn_level falls.
- pwron = tickcount[BLINK_BIT] & (tickcount[63:PWRON_BIT]==0).
- LED modes: 0 off; 1 on; 2 led_act ^ pwron; 3 tickcount[BLINK_BIT]. led_out registered, 1-cycle latency from led_mode/led_act. led_out=0 while sys_rst=1.
- Simultaneous press and release edges on different buttons are independent.

Optional Feature:
SYSCTL_LED_PWM_EN: when defined, adds parameter LED_DUTY (8 bits, default 8'd64) and a free 8-bit PWM counter; led_out = mode result & (pwm_cnt < LED_DUTY), registered. LED_DUTY=255 means on 255/256. When undefined, no PWM counter; led_out is the mode result directly.

Decomposition:
- pcileech_header.svh package additions: typedef enum logic[1:0] {LED_OFF, LED_ON, LED_ACT, LED_BLINK} led_mode_t; typedef enum {RST_ACTIVE, RST_HOLD, RUN} sysctl_rst_state_t.
- One sub-module: pcileech_sysctl_btn (synchroniser + debounce + hold counter + short/long pulses), generated NUM_BTN times.

Test Plan:
- DEBOUNCE_CYCLES=4, RST_HOLD_CYCLES=8: release rst_n -> sys_rst=1 for 8 cycles then 0; tickcount=8 on first RUN cycle.
- btn_n[0] low 3 cycles -> btn_level[0] stays 0; low 20 cycles -> btn_level[0] rises 6 cycles after falling edge.
- LONG_PRESS_CYCLES=50: press btn 0 for 30 cycles -> one btn_short pulse at release, no btn_long; hold 100 -> one btn_long at count 50, no btn_short.
- Hold RST_BTN 60 cycles mid-run -> sys_rst=1, tickcount=0, cfg_reload high from count 50 until release; after release sys_rst low 8 cycles later.
- BLINK_BIT=2, PWRON_BIT=5: mode 2, led_act=0 -> led_out toggles every 4 cycles until tickcount=32, then 0; mode 3 keeps toggling; mode 0 always 0.
- SYSCTL_LED_PWM_EN, LED_DUTY=64, mode 1 -> led_out high 64 of every 256 cycles.

Source files
------------

// File: rtl/pcileech_sysctl_pkg.sv
// Shared types and helpers for the board system-control block.
package pcileech_sysctl_pkg;

    typedef enum logic [1:0] {LED_OFF, LED_ON, LED_ACT, LED_BLINK} led_mode_t;
    typedef enum logic [1:0] {RST_ACTIVE, RST_HOLD, RUN} sysctl_rst_state_t;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pcileech_sysctl_btn.sv
// One active-low button: 2-FF synchroniser, debounce, hold counter and
// short/long press pulses.
module pcileech_sysctl_btn
    import pcileech_sysctl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int LONG_PRESS_CYCLES = 500000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic level,
    output logic short_pulse,
    output logic long_pulse,
    output logic long_held
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int HW = cnt_width(LONG_PRESS_CYCLES);

    logic [1:0]    sync;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;
    logic          toggle;

    assign toggle    = (sync[1] != level) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
    assign long_held = (hold_cnt == HW'(LONG_PRESS_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync        <= '0;
            db_cnt      <= '0;
            level       <= 1'b0;
            hold_cnt    <= '0;
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
        end else begin
            sync <= {sync[0], ~btn_n};
            if (sync[1] == level || toggle)
                db_cnt <= '0;
            else
                db_cnt <= db_cnt + 1'b1;
            if (toggle)
                level <= ~level;
            // Hold count saturates so the long pulse can only fire once per press.
            if (!level)
                hold_cnt <= '0;
            else if (!long_held)
                hold_cnt <= hold_cnt + 1'b1;
            long_pulse  <= level && (hold_cnt == HW'(LONG_PRESS_CYCLES - 1));
            short_pulse <= toggle && level && !long_held;
        end
    end

endmodule

// File: rtl/pcileech_sysctl.sv
// Board system control: reset sequencing, 64-bit tick, debounced buttons, LEDs.
// Optional LED dimming PWM enabled by defining SYSCTL_LED_PWM_EN.
module pcileech_sysctl
    import pcileech_sysctl_pkg::*;
#(
    parameter int NUM_BTN           = 2,
    parameter int NUM_LED           = 2,
    parameter int RST_BTN           = 1,
    parameter int RST_HOLD_CYCLES   = 64,
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int LONG_PRESS_CYCLES = 500000000,
    parameter int BLINK_BIT         = 24,
    parameter int PWRON_BIT         = 27
`ifdef SYSCTL_LED_PWM_EN
    ,
    parameter logic [7:0] LED_DUTY  = 8'd64
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BTN-1:0]     btn_n,
    output logic                   sys_rst,
    output logic [63:0]            tickcount,
    output logic [NUM_BTN-1:0]     btn_level,
    output logic [NUM_BTN-1:0]     btn_short,
    output logic [NUM_BTN-1:0]     btn_long,
    output logic                   cfg_reload,
    input  logic [2*NUM_LED-1:0]   led_mode,
    input  logic [NUM_LED-1:0]     led_act,
    output logic [NUM_LED-1:0]     led_out
);

    localparam int RW = cnt_width(RST_HOLD_CYCLES);

    logic [NUM_BTN-1:0] long_held;

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        pcileech_sysctl_btn #(
            .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
        ) u_btn (
            .clk         (clk),
            .rst_n       (rst_n),
            .btn_n       (btn_n[b]),
            .level       (btn_level[b]),
            .short_pulse (btn_short[b]),
            .long_pulse  (btn_long[b]),
            .long_held   (long_held[b])
        );
    end

    assign cfg_reload = btn_level[RST_BTN] & long_held[RST_BTN];

    sysctl_rst_state_t state, state_nxt;
    logic [RW-1:0]     rst_cnt, rst_cnt_nxt;

    always_comb begin
        state_nxt   = state;
        rst_cnt_nxt = rst_cnt;
        if (btn_level[RST_BTN]) begin
            state_nxt = RST_ACTIVE;
        end else begin
            case (state)
                RST_ACTIVE: begin
                    state_nxt   = RST_HOLD;
                    rst_cnt_nxt = '0;
                end
                RST_HOLD: begin
                    if (rst_cnt == RW'(RST_HOLD_CYCLES - 1))
                        state_nxt = RUN;
                    else
                        rst_cnt_nxt = rst_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sys_rst = (state != RUN);

    // Tick is held at 0 through RST_ACTIVE and its exit cycle, so the first
    // RUN cycle shows RST_HOLD_CYCLES after both power-on and button reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST_HOLD;
            rst_cnt   <= '0;
            tickcount <= '0;
        end else begin
            state   <= state_nxt;
            rst_cnt <= rst_cnt_nxt;
            if (state == RST_ACTIVE || state_nxt == RST_ACTIVE)
                tickcount <= '0;
            else
                tickcount <= tickcount + 64'd1;
        end
    end

    logic               pwron;
    logic [NUM_LED-1:0] led_res;

    assign pwron = tickcount[BLINK_BIT] & (tickcount[63:PWRON_BIT] == '0);

    always_comb begin
        led_res = '0;
        for (int i = 0; i < NUM_LED; i++) begin
            case (led_mode_t'(led_mode[2*i +: 2]))
                LED_OFF: led_res[i] = 1'b0;
                LED_ON:  led_res[i] = 1'b1;
                LED_ACT: led_res[i] = led_act[i] ^ pwron;
                default: led_res[i] = tickcount[BLINK_BIT];
            endcase
        end
    end

`ifdef SYSCTL_LED_PWM_EN
    logic [7:0] pwm_cnt;
    logic       pwm_on;

    assign pwm_on = (pwm_cnt < LED_DUTY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            led_out <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            led_out <= (state_nxt == RUN) ? (led_res & {NUM_LED{pwm_on}}) : '0;
        end
    end
`else
    // Gating on the next state keeps LEDs dark on every cycle sys_rst is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            led_out <= '0;
        else
            led_out <= (state_nxt == RUN) ? led_res : '0;
    end
`endif

endmodule

// File: tb/tb_pcileech_sysctl.sv
// Directed bench for pcileech_sysctl with small timing parameters.
module tb_pcileech_sysctl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  btn_n;
    logic        sys_rst;
    logic [63:0] tickcount;
    logic [1:0]  btn_level, btn_short, btn_long;
    logic        cfg_reload;
    logic [3:0]  led_mode;
    logic [1:0]  led_act;
    logic [1:0]  led_out;

    int n_cmp = 0;
    int n_err = 0;
    longint unsigned exp_tick;
    int sc [2];
    int lc [2];
    int base_s, base_l;

    always #5 clk = ~clk;

    pcileech_sysctl #(
        .NUM_BTN           (2),
        .NUM_LED           (2),
        .RST_BTN           (1),
        .RST_HOLD_CYCLES   (8),
        .DEBOUNCE_CYCLES   (4),
        .LONG_PRESS_CYCLES (50),
        .BLINK_BIT         (2),
        .PWRON_BIT         (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_n      (btn_n),
        .sys_rst    (sys_rst),
        .tickcount  (tickcount),
        .btn_level  (btn_level),
        .btn_short  (btn_short),
        .btn_long   (btn_long),
        .cfg_reload (cfg_reload),
        .led_mode   (led_mode),
        .led_act    (led_act),
        .led_out    (led_out)
    );

    initial begin
        sc[0] = 0; sc[1] = 0; lc[0] = 0; lc[1] = 0;
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int b = 0; b < 2; b++) begin
                if (btn_short[b]) sc[b] = sc[b] + 1;
                if (btn_long[b])  lc[b] = lc[b] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        exp_tick = exp_tick + 64'(n);
    endtask

    initial begin
        logic [63:0] p;
        logic [1:0]  exp_led;
        int          on_cnt;

        rst_n = 1'b0; btn_n = 2'b11; led_mode = '0; led_act = '0;
        exp_tick = 0;
        repeat (3) @(negedge clk);
        check("rst_sys_rst", 64'(sys_rst), 64'd1);
        check("rst_tick", tickcount, 64'd0);
        check("rst_level", 64'(btn_level), 64'd0);
        check("rst_short", 64'(btn_short), 64'd0);
        check("rst_long", 64'(btn_long), 64'd0);
        check("rst_cfg", 64'(cfg_reload), 64'd0);
        check("rst_led", 64'(led_out), 64'd0);

        // Power-on hold: eight cycles of sys_rst, tick 8 on first RUN cycle.
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("pwr_hold", 64'(sys_rst), 64'd1);
            @(negedge clk);
        end
        check("pwr_run", 64'(sys_rst), 64'd0);
        check("pwr_tick", tickcount, 64'd8);
        exp_tick = 8;

`ifndef SYSCTL_LED_PWM_EN
        // LED0 act^pwron with act=0, LED1 blink; output lags tick by one.
        led_mode = 4'b1110; led_act = 2'b00;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            p = 64'(exp_tick) - 64'd1;
            exp_led = {p[2], p[2] & (p < 64'd32)};
            check("led_blink", 64'(led_out), 64'(exp_led));
        end
        check("led_tick", tickcount, 64'd48);
        led_mode = 4'b0100; cyc(1);
        check("led_on_off", 64'(led_out), 64'd2);
        led_mode = 4'b0010; led_act = 2'b01; cyc(1);
        check("led_act", 64'(led_out), 64'd1);
        led_mode = 4'b0000; cyc(1);
        check("led_off", 64'(led_out), 64'd0);
`else
        led_mode = 4'b0101; cyc(1);
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            cyc(1);
            on_cnt += int'(led_out[0]);
        end
        check("pwm_duty", 64'(on_cnt), 64'd64);
        led_mode = 4'b0000;
`endif

        // Three-cycle glitch is rejected.
        btn_n[0] = 1'b0; cyc(3); btn_n[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check("glitch_level", 64'(btn_level[0]), 64'd0);
        end

        // 20-cycle press: level rises 6 cycles after press, one short pulse.
        base_s = sc[0]; base_l = lc[0];
        btn_n[0] = 1'b0;
        cyc(5); check("press_lat5", 64'(btn_level[0]), 64'd0);
        cyc(1); check("press_lat6", 64'(btn_level[0]), 64'd1);
        cyc(14); btn_n[0] = 1'b1;
        cyc(5); check("rel_level5", 64'(btn_level[0]), 64'd1);
        check("rel_short5", 64'(btn_short[0]), 64'd0);
        cyc(1); check("rel_level6", 64'(btn_level[0]), 64'd0);
        check("rel_short6", 64'(btn_short[0]), 64'd1);
        cyc(1); check("rel_short7", 64'(btn_short[0]), 64'd0);
        cyc(2);
        check("short_count", 64'(sc[0] - base_s), 64'd1);
        check("short_nolong", 64'(lc[0] - base_l), 64'd0);

        // 100-cycle press: single long pulse at count 50, no short.
        base_s = sc[0]; base_l = lc[0];
        btn_n[0] = 1'b0;
        cyc(55); check("long_pre", 64'(btn_long[0]), 64'd0);
        cyc(1);  check("long_hit", 64'(btn_long[0]), 64'd1);
        cyc(1);  check("long_post", 64'(btn_long[0]), 64'd0);
        cyc(43); btn_n[0] = 1'b1;
        cyc(10); check("long_rel", 64'(btn_level[0]), 64'd0);
        check("long_count", 64'(lc[0] - base_l), 64'd1);
        check("long_noshort", 64'(sc[0] - base_s), 64'd0);
        check("long_not_rst", 64'(sys_rst), 64'd0);

        // Reset button held 60 cycles mid-run.
        base_s = sc[1]; base_l = lc[1];
        led_mode = 4'b0101;
        btn_n[1] = 1'b0;
        cyc(6);  check("rb_pre", 64'(sys_rst), 64'd0);
        cyc(1);  check("rb_active", 64'(sys_rst), 64'd1);
        check("rb_tick0", tickcount, 64'd0);
        check("rb_led", 64'(led_out), 64'd0);
        cyc(48); check("rb_cfg55", 64'(cfg_reload), 64'd0);
        cyc(1);  check("rb_cfg56", 64'(cfg_reload), 64'd1);
        cyc(4);  btn_n[1] = 1'b1;
        cyc(5);  check("rb_cfg65", 64'(cfg_reload), 64'd1);
        check("rb_tick65", tickcount, 64'd0);
        cyc(1);  check("rb_cfg66", 64'(cfg_reload), 64'd0);
        check("rb_sys66", 64'(sys_rst), 64'd1);
        cyc(1);  check("rb_tick67", tickcount, 64'd0);
        check("rb_sys67", 64'(sys_rst), 64'd1);
        cyc(7);  check("rb_tick74", tickcount, 64'd7);
        check("rb_sys74", 64'(sys_rst), 64'd1);
        cyc(1);  check("rb_sys75", 64'(sys_rst), 64'd0);
        check("rb_tick75", tickcount, 64'd8);
        cyc(2);
        check("rb_long_count", 64'(lc[1] - base_l), 64'd1);
        check("rb_noshort", 64'(sc[1] - base_s), 64'd0);
        check("rb_led_run", 64'(led_out), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
